// File: rtl/pipo_fifo.sv
// pipo_fifo: parallel-in parallel-out FIFO that keeps its words in a small
// register array.
//
// Parameters
//   WIDTH : data word width in bits (1..64)
//   DEPTH : number of stored words (power of two, 2..64)
//
// Ports
//   clk   in   single clock; all state updates on the rising edge
//   rst_n in   synchronous active-low reset; it overrides flush, ld and rd
//              and clears the storage array
//   ld    in   write request; din is stored when the write is accepted
//   din   in   write data [WIDTH]
//   rd    in   read request; the word on dout is consumed when accepted
//   flush in   synchronous clear of pointers, occupancy and ovf; it takes
//              priority over ld/rd and leaves the array contents in place
//   dout  out  oldest stored word, read combinationally [WIDTH]
//   empty out  FIFO holds 0 words
//   full  out  FIFO holds DEPTH words
//   ovf   out  sticky overflow; set by a write refused while full, cleared
//              only by reset or flush
//   count out  occupancy 0..DEPTH [$clog2(DEPTH+1)]; present only when the
//              macro PIPO_FIFO_COUNT_EN is defined
//
// Configuration macro: PIPO_FIFO_COUNT_EN
module pipo_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf
`ifdef PIPO_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit above the array index, so that equal
  // index bits mean either empty (wrap bits equal) or full (wrap bits differ).
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ovf;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_set;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // An accepted read frees a slot at the same edge, so a write alongside it
  // is accepted even when full (pass-through at full occupancy).
  assign w_rd_acc  = rd & ~w_empty;
  assign w_wr_acc  = ld & (~w_full | w_rd_acc);
  assign w_ovf_set = ld & ~w_wr_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_mem  <= '{default: '0};
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_mem[r_wptr[AW-1:0]] <= din;
        r_wptr                <= r_wptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef PIPO_FIFO_COUNT_EN
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
`endif

  assign dout  = r_mem[r_rptr[AW-1:0]];
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_pipo_fifo.sv
// tb_pipo_fifo: self-checking bench for pipo_fifo (WIDTH=16, DEPTH=4).
// A queue-based reference model tracks the FIFO contents and the sticky
// overflow flag; directed scenarios are followed by randomized traffic.
module tb_pipo_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             ld;
  logic [WIDTH-1:0] din;
  logic             rd;
  logic             flush;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             ovf;
`ifdef PIPO_FIFO_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] count;
`endif

  pipo_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (ld),
    .din  (din),
    .rd   (rd),
    .flush(flush),
    .dout (dout),
    .empty(empty),
    .full (full),
    .ovf  (ovf)
`ifdef PIPO_FIFO_COUNT_EN
    ,
    .count(count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_ovf;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_model();
    check("empty", 64'(empty), 64'(mq.size() == 0));
    check("full", 64'(full), 64'(mq.size() == DEPTH));
    check("ovf", 64'(ovf), 64'(m_ovf));
    if (mq.size() > 0) check("dout", 64'(dout), 64'(mq[0]));
`ifdef PIPO_FIFO_COUNT_EN
    check("count", 64'(count), 64'(mq.size()));
`endif
  endtask

  // One clock edge with the given inputs; the model applies the FIFO rules
  // to its queue, then outputs are compared 1 time unit after the edge.
  task automatic step(input logic l, input logic [WIDTH-1:0] d,
                      input logic r, input logic f, input logic rn);
    bit rd_ok, wr_ok;
    ld = l; din = d; rd = r; flush = f; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (f) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      rd_ok = r && (mq.size() > 0);
      wr_ok = l && ((mq.size() < DEPTH) || rd_ok);
      if (l && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(d);
    end
    #1;
    check_model();
    if (!rn) check("rst_dout", 64'(dout), 64'h0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic fill4();
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h4444, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] rdat [4];
    rdat[0] = 16'h1111; rdat[1] = 16'h2222;
    rdat[2] = 16'h3333; rdat[3] = 16'h4444;
    m_ovf = 1'b0;
    ld = 1'b0; din = '0; rd = 1'b0; flush = 1'b0; rst_n = 1'b0;

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h9999, 1'b1, 1'b1, 1'b0);
    check("rst_empty", 64'(empty), 64'h1);

    // Fill to full
    fill4();
    check("fill_full", 64'(full), 64'h1);
    check("fill_ovf", 64'(ovf), 64'h0);

    // Overflow while full, then drain in order
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
    check("ovf_set", 64'(ovf), 64'h1);
    for (int i = 0; i < 4; i++) begin
      check("drain_dout", 64'(dout), 64'(rdat[i]));
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    check("drain_empty", 64'(empty), 64'h1);
    check("ovf_sticky", 64'(ovf), 64'h1);

    // Pass-through at full
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    fill4();
    step(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b1);
    check("pt_dout", 64'(dout), 64'h2222);
    check("pt_full", 64'(full), 64'h1);
    check("pt_ovf", 64'(ovf), 64'h0);

    // Simultaneous ld/rd while empty, then pointer wrap with occupancy 1
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    check("le_empty", 64'(empty), 64'h0);
    check("le_dout", 64'(dout), 64'hBEEF);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'hC000 + i), 1'b1, 1'b0, 1'b1);
      check("wrap_dout", 64'(dout), 64'(16'hC000 + i));
    end

    // Flush with ld: 3 words stored and ovf set beforehand
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    fill4();
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("pre_flush_ovf", 64'(ovf), 64'h1);
    step(1'b1, 16'h7777, 1'b0, 1'b1, 1'b1);
    check("flush_empty", 64'(empty), 64'h1);
    check("flush_ovf", 64'(ovf), 64'h0);

    // Same again with reset instead of flush
    fill4();
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
    check("mrst_empty", 64'(empty), 64'h1);
    check("mrst_dout", 64'(dout), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic l, r, f, rn;
      rn = ($urandom_range(0, 63) != 0);
      f  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 5);
      step(l, 16'($urandom), r, f, rn);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
